tree_classifier: RTL and testbench

- Decision-tree classification stage directly downstream of the camera pretreatment stage.
- On the frame-final `lable_start` pulse it latches the dark/bright pixel counts `feature0`/`feature1`.
- It walks a fixed node table one node per clock and drives the one-hot class `tree_out`, which pretreatment uses to select the 32x32 overlay glyph.
- `tree_out` holds until the next decision.

---
 rtl/tree_pkg.sv | 83 ++++++++
 rtl/tree_node_rom.sv | 12 +
 rtl/tree_classifier.sv | 163 ++++++++++++++++
 tb/tb_tree_classifier.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared types, class encodings and the default node table for tree_classifier.
// Optional decision voting is enabled with TREE_VOTE_EN.
package tree_pkg;

  localparam int TREE_FEAT_W  = 20;
  localparam int TREE_NODE_AW = 3;
  localparam int TREE_NODES   = 1 << TREE_NODE_AW;

  typedef logic [1:0] cls_t;

  localparam cls_t CLS_A   = 2'd0;
  localparam cls_t CLS_B   = 2'd1;
  localparam cls_t CLS_C   = 2'd2;
  localparam cls_t CLS_UNK = 2'd3;

  localparam logic [3:0] OH_A   = 4'b0001;
  localparam logic [3:0] OH_B   = 4'b0010;
  localparam logic [3:0] OH_C   = 4'b0100;
  localparam logic [3:0] OH_UNK = 4'b1000;

  typedef enum logic [1:0] {
    SEL_F0,
    SEL_F1,
    SEL_SUM,
    SEL_RSVD
  } feat_sel_e;

  typedef logic [TREE_NODE_AW-1:0] node_idx_t;

  typedef struct packed {
    logic                   is_leaf;
    feat_sel_e              feat_sel;
    logic [TREE_FEAT_W-1:0] thresh;
    node_idx_t              left;
    node_idx_t              right;
    cls_t                   leaf_cls;
  } node_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WALK,
    ST_DONE
  } state_e;

  function automatic node_t mk_leaf(cls_t c);
    node_t n;
    n          = '0;
    n.is_leaf  = 1'b1;
    n.leaf_cls = c;
    return n;
  endfunction

  function automatic node_t mk_split(
    feat_sel_e              s,
    logic [TREE_FEAT_W-1:0] th,
    node_idx_t              l,
    node_idx_t              r
  );
    node_t n;
    n          = '0;
    n.feat_sel = s;
    n.thresh   = th;
    n.left     = l;
    n.right    = r;
    return n;
  endfunction

  function automatic logic [3:0] cls_onehot(cls_t c);
    return 4'b0001 << c;
  endfunction

  localparam node_t TREE_TABLE [TREE_NODES] = '{
    mk_split(SEL_F0, 20'd20000, 3'd1, 3'd2),
    mk_leaf(CLS_A),
    mk_split(SEL_F0, 20'd60000, 3'd3, 3'd4),
    mk_leaf(CLS_B),
    mk_leaf(CLS_C),
    mk_leaf(CLS_UNK),
    mk_leaf(CLS_UNK),
    mk_leaf(CLS_UNK)
  };

endpackage

// File: rtl/tree_node_rom.sv
// Combinational node lookup into the package node table.
// Node index in, full node record out.
module tree_node_rom
  import tree_pkg::*;
(
  input  node_idx_t idx,
  output node_t     rec
);

  assign rec = TREE_TABLE[idx];

endmodule

// File: rtl/tree_classifier.sv
// Decision-tree classifier: walks the node table one node per clock.
// Define TREE_VOTE_EN for 2-of-3 majority voting over past decisions.
module tree_classifier
  import tree_pkg::*;
#(
  parameter int FEAT_W    = TREE_FEAT_W,
  parameter int NODE_AW   = TREE_NODE_AW,
  parameter int MAX_STEPS = 8
) (
  input  logic              cam_pclk,
  input  logic              rst_n,
  input  logic              lable_start,
  input  logic [FEAT_W-1:0] feature0,
  input  logic [FEAT_W-1:0] feature1,
  output logic [3:0]        tree_out,
  output logic              class_valid,
  output logic              busy
);

  localparam int STEP_W =
    (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP =
    STEP_W'(MAX_STEPS - 1);

  state_e              state_q, state_d;
  logic [FEAT_W-1:0]   f0_q, f0_d;
  logic [FEAT_W-1:0]   f1_q, f1_d;
  logic [NODE_AW-1:0]  node_q, node_d;
  logic [STEP_W-1:0]   step_q, step_d;
  cls_t                cls_q, cls_d;
  logic [3:0]          out_q, out_d;
  logic                valid_q, valid_d;

  node_t               rec;
  logic [FEAT_W:0]     sel_val;
  logic                go_left;
  logic [3:0]          dec_oh;

  tree_node_rom u_rom (
    .idx (node_idx_t'(node_q)),
    .rec (rec)
  );

  always_comb begin
    sel_val = {1'b0, f0_q};
    unique case (rec.feat_sel)
      SEL_F1:  sel_val = {1'b0, f1_q};
      SEL_SUM: sel_val = {1'b0, f0_q} + {1'b0, f1_q};
      default: sel_val = {1'b0, f0_q};
    endcase
  end

  assign go_left = sel_val < (FEAT_W + 1)'(rec.thresh);

`ifdef TREE_VOTE_EN
  cls_t h0_q, h0_d;
  cls_t h1_q, h1_d;

  // No majority among {new, h0, h1} keeps the previous output.
  always_comb begin
    h0_d   = h0_q;
    h1_d   = h1_q;
    dec_oh = out_q;
    if (cls_q == h0_q || cls_q == h1_q) begin
      dec_oh = cls_onehot(cls_q);
    end else if (h0_q == h1_q) begin
      dec_oh = cls_onehot(h0_q);
    end
    if (state_q == ST_DONE) begin
      h0_d = cls_q;
      h1_d = h0_q;
    end
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      h0_q <= CLS_UNK;
      h1_q <= CLS_UNK;
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
    end
  end
`else
  assign dec_oh = cls_onehot(cls_q);
`endif

  always_comb begin
    state_d = state_q;
    f0_d    = f0_q;
    f1_d    = f1_q;
    node_d  = node_q;
    step_d  = step_q;
    cls_d   = cls_q;
    out_d   = out_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (lable_start) begin
          f0_d    = feature0;
          f1_d    = feature1;
          node_d  = '0;
          step_d  = '0;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (rec.is_leaf) begin
          cls_d   = rec.leaf_cls;
          state_d = ST_DONE;
        end else if (step_q == LAST_STEP) begin
          cls_d   = CLS_UNK;
          state_d = ST_DONE;
        end else begin
          node_d = go_left ? NODE_AW'(rec.left)
                           : NODE_AW'(rec.right);
          step_d = step_q + 1'b1;
        end
      end
      ST_DONE: begin
        out_d   = dec_oh;
        valid_d = 1'b1;
        state_d = ST_IDLE;
        // Last cycle of a decision already admits the next request.
        if (lable_start) begin
          f0_d    = feature0;
          f1_d    = feature1;
          node_d  = '0;
          step_d  = '0;
          state_d = ST_WALK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      f0_q    <= '0;
      f1_q    <= '0;
      node_q  <= '0;
      step_q  <= '0;
      cls_q   <= CLS_UNK;
      out_q   <= OH_UNK;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      node_q  <= node_d;
      step_q  <= step_d;
      cls_q   <= cls_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign tree_out    = out_q;
  assign class_valid = valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tree_classifier.sv
// Randomized scoreboard bench for tree_classifier (default and MAX_STEPS=2).
// Reference model follows the tree rules and timing formulas directly.
module tb_tree_classifier;

  logic        cam_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lable_start = 1'b0;
  logic [19:0] feature0 = '0;
  logic [19:0] feature1 = '0;
  logic [3:0]  tout0, tout1;
  logic        cv0, cv1, bz0, bz1;

  tree_classifier dut0 (
    .cam_pclk    (cam_pclk),
    .rst_n       (rst_n),
    .lable_start (lable_start),
    .feature0    (feature0),
    .feature1    (feature1),
    .tree_out    (tout0),
    .class_valid (cv0),
    .busy        (bz0)
  );

  tree_classifier #(.MAX_STEPS(2)) dut1 (
    .cam_pclk    (cam_pclk),
    .rst_n       (rst_n),
    .lable_start (lable_start),
    .feature0    (feature0),
    .feature1    (feature1),
    .tree_out    (tout1),
    .class_valid (cv1),
    .busy        (bz1)
  );

  always #5 cam_pclk = ~cam_pclk;

  int edge_n = 0;
  always @(posedge cam_pclk) edge_n <= edge_n + 1;

  typedef struct {
    logic [3:0] oh;
    int         at;
  } exp_t;

  exp_t       q[2][$];
  int         free_at[2];
  int         w_lo[2];
  int         w_hi[2];
  int         hist[2][2];
  logic [3:0] last_oh[2];
  logic [3:0] shown[2];
  logic       pv[2];
  int         errs = 0;
  int         chks = 0;

  function automatic int max_steps(input int k);
    return (k == 0) ? 8 : 2;
  endfunction

  function automatic logic [3:0] oh(input int c);
    logic [3:0] r;
    r = 4'b0001 << c;
    return r;
  endfunction

  // Default table uses only f0: n0 splits at 20000, n2 at 60000.
  task automatic ref_tree(input logic [19:0] f0,
                          output int cls, output int depth);
    if (f0 < 20'd20000) begin
      cls = 0; depth = 1;
    end else if (f0 < 20'd60000) begin
      cls = 1; depth = 2;
    end else begin
      cls = 2; depth = 2;
    end
  endtask

  task automatic vote(input int k, input int c, output logic [3:0] r);
`ifdef TREE_VOTE_EN
    int cnt[4];
    cnt = '{default: 0};
    cnt[c]++;
    cnt[hist[k][0]]++;
    cnt[hist[k][1]]++;
    r = last_oh[k];
    for (int i = 0; i < 4; i++) if (cnt[i] >= 2) r = oh(i);
    hist[k][1] = hist[k][0];
    hist[k][0] = c;
`else
    r = oh(c);
`endif
    last_oh[k] = r;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      free_at[k] = 0;
      w_lo[k]    = 0;
      w_hi[k]    = 0;
      hist[k][0] = 3;
      hist[k][1] = 3;
      last_oh[k] = 4'b1000;
      shown[k]   = 4'b1000;
      pv[k]      = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    chks++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at edge %0d",
               nm, act, expv, edge_n);
    end
  endtask

  task automatic mon(input int k, input logic v,
                     input logic [3:0] t, input logic b);
    exp_t e;
    chk($sformatf("busy%0d", k), b,
        (edge_n >= w_lo[k] && edge_n < w_hi[k]));
    if (pv[k]) chk($sformatf("valid_width%0d", k), v, 0);
    if (v) begin
      if (q[k].size() == 0) begin
        chks++; errs++;
        $display("FAIL unexpected_valid%0d: got class_valid=1 expected 0 at edge %0d",
                 k, edge_n);
      end else begin
        e = q[k].pop_front();
        shown[k] = e.oh;
        chk($sformatf("class%0d", k), t, e.oh);
        chk($sformatf("latency%0d", k), edge_n, e.at);
      end
    end else begin
      chk($sformatf("hold%0d", k), t, shown[k]);
      if (q[k].size() > 0 && q[k][0].at < edge_n) begin
        chks++; errs++;
        $display("FAIL missing_valid%0d: got none expected pulse at edge %0d",
                 k, q[k][0].at);
        void'(q[k].pop_front());
      end
    end
    pv[k] = v;
  endtask

  always @(negedge cam_pclk) begin
    mon(0, cv0, tout0, bz0);
    mon(1, cv1, tout1, bz1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge cam_pclk);
      #1;
      feature0 = 20'($urandom);
      feature1 = 20'($urandom);
    end
  endtask

  task automatic issue(input logic [19:0] f0, input logic [19:0] f1);
    int e0, c, d, lat;
    logic [3:0] r;
    e0 = edge_n + 1;
    lable_start = 1'b1;
    feature0 = f0;
    feature1 = f1;
    for (int k = 0; k < 2; k++) begin
      if (e0 >= free_at[k]) begin
        ref_tree(f0, c, d);
        lat = d + 2;
        if (d >= max_steps(k)) begin
          c   = 3;
          lat = max_steps(k) + 1;
        end
        vote(k, c, r);
        q[k].push_back('{oh: r, at: e0 + lat});
        free_at[k] = e0 + lat;
        w_lo[k]    = e0;
        w_hi[k]    = e0 + lat;
      end
    end
    @(negedge cam_pclk);
    #1;
    lable_start = 1'b0;
    feature0 = 20'($urandom);
    feature1 = 20'($urandom);
  endtask

  function automatic logic [19:0] pick_f0();
    logic [19:0] v;
    case ($urandom_range(0, 7))
      0: v = 20'd10000;
      1: v = 20'd19999;
      2: v = 20'd20000;
      3: v = 20'd59999;
      4: v = 20'd60000;
      5: v = 20'd40000;
      6: v = 20'hFFFFF;
      default: v = 20'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int wait_n;
    logic [19:0] dir_f0 [5];
    dir_f0 = '{20'd10000, 20'd40000, 20'd40000, 20'd90000, 20'd10000};
    model_reset();
    repeat (3) @(negedge cam_pclk);
    #1;
    chk("rst_tree_out", tout0, 4'b1000);
    chk("rst_valid", cv0, 0);
    chk("rst_busy", bz0, 0);
    rst_n = 1'b1;
    idle(3);

    foreach (dir_f0[i]) begin
      issue(dir_f0[i], 20'($urandom));
      idle(6);
    end
    issue(20'd60000, 20'd0);  idle(6);
    issue(20'd59999, 20'd5);  idle(6);
    issue(20'd20000, 20'd7);  idle(6);
    issue(20'd19999, 20'd9);  idle(6);

    issue(20'd10000, 20'd0);
    issue(20'd90000, 20'd0);
    idle(1);
    issue(20'd40000, 20'd0);
    idle(6);

    for (int n = 0; n < 200; n++) begin
      issue(pick_f0(), 20'($urandom));
      idle($urandom_range(0, 4));
    end

    wait_n = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && wait_n < 40) begin
      idle(1);
      wait_n++;
    end
    chk("drain", q[0].size() + q[1].size(), 0);

    idle(2);
    issue(20'd40000, 20'd0);
    @(negedge cam_pclk);
    #1;
    rst_n = 1'b0;
    model_reset();
    idle(3);
    chk("midrst_tree_out", tout0, 4'b1000);
    chk("midrst_busy", bz0, 0);
    rst_n = 1'b1;
    idle(6);
    chk("post_tree_out", tout0, 4'b1000);
    chk("post_valid", cv0, 0);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
